raster_scan_ctrl: RTL
=====================

Name: raster_scan_ctrl

Overview:
- Sequences the barycentric coefficient pipeline for one triangle at a time.
- Accepts a triangle, computes its screen-clamped bounding box, and issues one pixel point per cycle into the barycentric unit in raster order (x fastest).
- Tracks points in flight through the fixed-latency pipeline and signals completion once the last result has returned.
- Sits between the triangle setup stage and the barycentric/interpolation stage.

Parameters:
- H_RES, 320, screen width in pixels; x is clamped to [0, H_RES-1].
- V_RES, 240, screen height in pixels; y is clamped to [0, V_RES-1].
- MAX_INFLIGHT, 32, maximum issued-but-unreturned points; matches barycentric latency.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- tri_valid_in  input  1  triangle offered.
- tri_ready_out  output  1  controller can accept a triangle.
- vertices_in  input  [2:0][1:0][16:0]  triangle vertices; [1]=y, [0]=x; signed two's-complement integer pixels.
- hold_in  input  1  downstream stall; no point is issued in a cycle where hold_in=1.
- bary_valid_out  output  1  point_out/bary_vertices_out valid this cycle.
- point_out  output  [1:0][16:0]  pixel point to test; [1]=y, [0]=x.
- bary_vertices_out  output  [2:0][1:0][16:0]  latched triangle vertices, stable for the whole triangle.
- bary_result_in  input  1  barycentric valid_out; one pulse per returned point.
- busy_out  output  1  triangle in progress (state != IDLE).
- done_out  output  1  one-cycle pulse once the last result of a triangle has returned.

Behaviour:
- Reset values: tri_ready_out=0 during reset and 1 on the first cycle after reset; all other outputs 0; state IDLE; counters 0.
- Reset mid-triangle aborts immediately:
  - Outputs and counters are cleared.
  - Results still arriving on bary_result_in afterwards are ignored; the in-flight counter saturates at 0 and never decrements below it.
- States: IDLE, BOUND, SCAN, DRAIN, DONE.
- IDLE:
  - tri_ready_out=1.
  - On tri_valid_in&&tri_ready_out, latch vertices_in and go to BOUND.
- BOUND (1 cycle):
  - xmin/xmax/ymin/ymax = signed min/max over the three vertices.
  - Clamp mins to >=0 and maxes to <=RES-1.
  - If xmin>xmax or ymin>ymax (triangle fully off-screen), go to DONE with zero points issued.
  - Otherwise set cursor=(xmin,ymin) and go to SCAN.
- SCAN:
  - Issue when !hold_in && inflight<MAX_INFLIGHT.
  - On issue: bary_valid_out=1 (registered) and point_out=cursor.
  - Cursor advance: x increments; at x==xmax, x wraps to xmin and y increments.
  - Issuing (xmax,ymax) goes to DRAIN.
  - No issue: bary_valid_out=0 and cursor holds.
- DRAIN: wait until inflight==0, then go to DONE.
- DONE (1 cycle): done_out=1, then go to IDLE.
- Each triangle gives exactly one done_out, including the empty-bbox case.
- In-flight counter, width clog2(MAX_INFLIGHT+1):
  - +1 per issue, -1 per bary_result_in.
  - Simultaneous issue and return leaves it unchanged.
  - A return with counter==0 is ignored.
- Point count per triangle = (xmax-xmin+1)*(ymax-ymin+1).
- Total latency for an N-point unstalled triangle, from accept to done_out: 1 (BOUND) + N + 32 + 1 cycles.
- bary_vertices_out updates only on accept.
- tri_ready_out=0 in every state except IDLE; tri_valid_in is ignored while busy.
- Min/max and clamp comparisons are signed 17-bit; point_out coordinates are always non-negative.

Test Plan:
- Vertices (2,2),(4,2),(2,3), hold_in=0, bary_result_in driven 32 cycles after each issue -> 6 points in order (2,2),(3,2),(4,2),(2,3),(3,3),(4,3) on consecutive cycles; done_out exactly 1+6+32+1=40 cycles after accept; tri_ready_out returns to 1 the next cycle.
- Vertices (-5,-5),(1,-5),(-5,0) -> bbox clamped to x 0..1, y 0..0; points (0,0),(1,0) only.
- All vertices at x=-10 (fully off-screen) -> no bary_valid_out; done_out 2 cycles after accept.
- hold_in=1 on cycles 2-4 of SCAN, results never returned with MAX_INFLIGHT=4 on an 8x1 bbox -> issue stops after 4 points; resumes one point per returned result; cursor never skips or repeats.
- Assert rst_in asynchronously mid-SCAN -> outputs 0 immediately; the controller accepts a new triangle after release; stale bary_result_in pulses leave the counter at 0.
- Single-pixel triangle (7,7)x3 -> one point (7,7); done_out after its result returns.

Source files
------------

// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: walks the screen-clamped bounding box of one triangle in
// raster order (x fastest), issuing one pixel point per cycle into the
// fixed-latency barycentric unit. It tracks points in flight and pulses
// done_out once the last result of the triangle has come back.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   tri_valid_in/_ready_out triangle handshake from the setup stage
//   vertices_in             three (x,y) vertices, signed 17-bit, [1]=y [0]=x
//   hold_in                 downstream stall, blocks issue
//   bary_valid_out          point_out is valid this cycle
//   point_out               pixel to test, [1]=y [0]=x
//   bary_vertices_out       vertices latched at accept
//   bary_result_in          one pulse per point returned by the barycentric unit
//   busy_out                triangle in progress
//   done_out                one-cycle pulse when the triangle is complete
module raster_scan_ctrl #(
  parameter int unsigned H_RES        = 320,
  parameter int unsigned V_RES        = 240,
  parameter int unsigned MAX_INFLIGHT = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  tri_valid_in,
  output logic                  tri_ready_out,
  input  logic [2:0][1:0][16:0] vertices_in,
  input  logic                  hold_in,
  output logic                  bary_valid_out,
  output logic [1:0][16:0]      point_out,
  output logic [2:0][1:0][16:0] bary_vertices_out,
  input  logic                  bary_result_in,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned CW = 17;
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

  localparam logic signed [CW-1:0] ZERO   = '0;
  localparam logic signed [CW-1:0] X_LAST = CW'(H_RES - 1);
  localparam logic signed [CW-1:0] Y_LAST = CW'(V_RES - 1);
  localparam logic [IW-1:0]        INF_MAX = IW'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUND,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0][1:0][CW-1:0] vert_q, vert_d;
  logic [CW-1:0]           xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic [CW-1:0]           cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [1:0][CW-1:0]      point_q, point_d;
  logic [IW-1:0]           inflight_q, inflight_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    issue;
  logic                    ret;
  logic signed [CW-1:0]    bx_lo, bx_hi, by_lo, by_hi;

  function automatic logic signed [CW-1:0] smin(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [CW-1:0] smax(input logic signed [CW-1:0] a,
                                                input logic signed [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Signed bounding box of the latched vertices, clamped to the screen.
  always_comb begin
    bx_lo = smax(smin(smin($signed(vert_q[0][0]), $signed(vert_q[1][0])),
                      $signed(vert_q[2][0])), ZERO);
    bx_hi = smin(smax(smax($signed(vert_q[0][0]), $signed(vert_q[1][0])),
                      $signed(vert_q[2][0])), X_LAST);
    by_lo = smax(smin(smin($signed(vert_q[0][1]), $signed(vert_q[1][1])),
                      $signed(vert_q[2][1])), ZERO);
    by_hi = smin(smax(smax($signed(vert_q[0][1]), $signed(vert_q[1][1])),
                      $signed(vert_q[2][1])), Y_LAST);
  end

  // A return with nothing outstanding (e.g. stale after reset) is dropped.
  assign ret = bary_result_in && (inflight_q != '0);

  // Next-state, scan cursor and in-flight accounting.
  always_comb begin
    state_d    = state_q;
    vert_d     = vert_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymax_d     = ymax_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    point_d    = point_q;
    valid_d    = 1'b0;
    inflight_d = inflight_q;
    issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tri_valid_in && ready_q) begin
          vert_d  = vertices_in;
          state_d = S_BOUND;
        end
      end
      S_BOUND: begin
        xmin_d  = bx_lo;
        xmax_d  = bx_hi;
        ymax_d  = by_hi;
        cur_x_d = bx_lo;
        cur_y_d = by_lo;
        state_d = (bx_lo > bx_hi || by_lo > by_hi) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        // A result returning this cycle frees its slot for a new issue.
        if (!hold_in && (inflight_q < INF_MAX || ret)) begin
          issue      = 1'b1;
          valid_d    = 1'b1;
          point_d[1] = cur_y_q;
          point_d[0] = cur_x_q;
          if (cur_x_q == xmax_q) begin
            cur_x_d = xmin_q;
            cur_y_d = cur_y_q + CW'(1);
            if (cur_y_q == ymax_q) state_d = S_DRAIN;
          end else begin
            cur_x_d = cur_x_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 || (inflight_q == IW'(1) && ret)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue && !ret) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!issue && ret) begin
      inflight_d = inflight_q - IW'(1);
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      vert_q     <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      point_q    <= '0;
      inflight_q <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vert_q     <= vert_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymax_q     <= ymax_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      point_q    <= point_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tri_ready_out     = ready_q;
  assign bary_valid_out    = valid_q;
  assign point_out         = point_q;
  assign bary_vertices_out = vert_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;

endmodule
